div_unit: RTL and testbench



---
 rtl/div_pkg.sv | 19 +
 rtl/div_unit_if.sv | 37 +++
 rtl/div_step.sv | 35 +++
 rtl/div_unit.sv | 126 ++++++++++++
 tb/tb_div_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the execute-stage integer divider.
//   DIV_WIDTH   : default operand width (MIPS GPR width)
//   DIV_CYCLES  : restoring iterations per divide (one quotient bit per cycle)
//   div_state_t : divider FSM encoding
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CYCLES = DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        END  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
// Operand/result bundle between the execute stage and the divider.
//   start      : EX holds DIV/DIVU (held high while the pipeline is stalled)
//   signed_div : 1 = DIV, 0 = DIVU
//   annul      : exception flush, aborts the current operation
//   opdata1    : dividend (rs)
//   opdata2    : divisor (rt)
//   result     : {HI = remainder, LO = quotient}, registered
//   ready      : result valid this cycle
//   stall_div  : stall request to the hazard unit
// master = pipeline side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_unit_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic               start;
    logic               signed_div;
    logic               annul;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               stall_div;

    modport master (
        output start, signed_div, annul, opdata1, opdata2,
        input  result, ready, stall_div
    );

    modport slave (
        input  start, signed_div, annul, opdata1, opdata2,
        output result, ready, stall_div
    );
endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   rem_in  : WIDTH+1-bit partial remainder before the shift
//   dvd_bit : next dividend bit shifted into the remainder
//   divisor : divisor magnitude
//   rem_out : partial remainder after trial subtraction / restore
//   q_bit   : resulting quotient bit
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        // The sign of the trial subtraction is the comparison result; when it
        // is non-negative the difference is below the divisor, so its low
        // WIDTH+1 bits carry the whole value.
        q_bit   = (shifted >= {2'b00, divisor});
        diff    = shifted[WIDTH:0] - {1'b0, divisor};
        rem_out = q_bit ? diff : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle signed/unsigned divider for the MIPS execute stage. Iterates one
// quotient bit per cycle over magnitudes, then fixes up signs.
//   clk    : pipeline clock, rising edge
//   resetn : asynchronous, active-low reset
//   bus    : div_unit_if.slave (operands, annul, result, ready, stall_div)
// Divide by zero yields result 0 after a single stall cycle.
// -----------------------------------------------------------------------------
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH:0]     rem_reg;
    logic [WIDTH-1:0]   dvd_reg;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dsr_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic [2*WIDTH-1:0] result_reg;
    logic               ready_reg;

    logic               op1_neg;
    logic               op2_neg;
    logic [WIDTH-1:0]   op1_mag;
    logic [WIDTH-1:0]   op2_mag;
    logic [WIDTH:0]     step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   final_q;
    logic [WIDTH-1:0]   fix_q;
    logic [WIDTH-1:0]   fix_r;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_reg),
        .dvd_bit (dvd_reg[WIDTH-1]),
        .divisor (dsr_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        op1_neg = bus.signed_div & bus.opdata1[WIDTH-1];
        op2_neg = bus.signed_div & bus.opdata2[WIDTH-1];
        // The most negative value maps onto itself, which read as unsigned is
        // exactly its magnitude, so no extra bit is needed here.
        op1_mag = op1_neg ? (~bus.opdata1 + 1'b1) : bus.opdata1;
        op2_mag = op2_neg ? (~bus.opdata2 + 1'b1) : bus.opdata2;
        // Final iteration results, taken straight from the step so the result
        // is loaded on the same edge as the last quotient bit.
        final_q = {dvd_reg[WIDTH-2:0], step_q};
        fix_q   = neg_q_reg ? (~final_q + 1'b1) : final_q;
        fix_r   = neg_r_reg ? (~step_rem[WIDTH-1:0] + 1'b1) : step_rem[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            dvd_reg    <= '0;
            dsr_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
            ready_reg  <= 1'b0;
        end else if (bus.annul) begin
            // Flush wins in every state; result is deliberately left alone.
            state_reg <= IDLE;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b0;
                    if (bus.start) begin
                        if (bus.opdata2 == '0) begin
                            result_reg <= '0;
                            ready_reg  <= 1'b1;
                            state_reg  <= END;
                        end else begin
                            rem_reg   <= '0;
                            dvd_reg   <= op1_mag;
                            dsr_reg   <= op2_mag;
                            neg_q_reg <= op1_neg ^ op2_neg;
                            neg_r_reg <= op1_neg;
                            cnt_reg   <= '0;
                            state_reg <= ON;
                        end
                    end
                end
                ON: begin
                    rem_reg <= step_rem;
                    dvd_reg <= final_q;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        result_reg <= {fix_r, fix_q};
                        ready_reg  <= 1'b1;
                        state_reg  <= END;
                    end
                end
                END: begin
                    // The pipeline advances this cycle; start is not looked at.
                    ready_reg <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    ready_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.result    = result_reg;
    assign bus.ready     = ready_reg;
    assign bus.stall_div = bus.start & ~ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Directed and randomized checks of div_unit against an arithmetic model
// (64-bit signed division, truncating toward zero).
// -----------------------------------------------------------------------------
module tb_div_unit;
    import div_pkg::*;

    localparam int W = DIV_WIDTH;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;
    logic [2*W-1:0] last_result;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issues one divide in the next IDLE cycle, keeps start high like a stalled
    // EX stage, scrambles the operands after the sampling cycle, and returns in
    // the ready cycle with start still high (so the next call is back-to-back).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input string tag);
        int          stalls;
        bit          seen;
        int          exp_stalls;
        logic [63:0] exp;
        exp        = ref_div(a, b, sgn);
        exp_stalls = (b == 32'd0) ? 1 : DIV_CYCLES + 1;
        @(posedge clk); #1;
        check({tag, ":ready_low_before"}, 64'(bus.ready), 64'd0);
        bus.start      = 1'b1;
        bus.signed_div = sgn;
        bus.opdata1    = a;
        bus.opdata2    = b;
        #1;
        stalls = 0;
        seen   = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.ready) begin
                seen = 1;
                break;
            end
            if (bus.stall_div) stalls++;
            @(posedge clk); #2;
            if (i == 0) begin
                bus.opdata1    = $urandom;
                bus.opdata2    = $urandom;
                bus.signed_div = ~sgn;
            end
        end
        check({tag, ":ready_seen"}, 64'(seen), 64'd1);
        check({tag, ":stall_cycles"}, 64'(stalls), 64'(exp_stalls));
        check({tag, ":result"}, bus.result, exp);
        check({tag, ":stall_in_ready"}, 64'(bus.stall_div), 64'd0);
        $display("div %s a=%h b=%h signed=%0d result=%h stalls=%0d", tag, a, b, sgn,
                 bus.result, stalls);
        last_result = exp;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.annul      = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        last_result    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset:result", bus.result, 64'd0);
        check("reset:ready", 64'(bus.ready), 64'd0);
        check("reset:stall", 64'(bus.stall_div), 64'd0);
        @(negedge clk) resetn = 1'b1;

        // Directed cases with hand-computed results.
        run_div(32'd100, 32'd7, 1'b0, "u100_7");
        check("u100_7:const", bus.result, {32'd2, 32'd14});
        run_div(-32'sd7, 32'd2, 1'b1, "s-7_2");
        check("s-7_2:const", bus.result, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_div(32'd7, -32'sd2, 1'b1, "s7_-2");
        check("s7_-2:const", bus.result, {32'h00000001, 32'hFFFFFFFD});
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "smin_-1");
        check("smin_-1:const", bus.result, {32'h0, 32'h80000000});
        run_div(32'hFFFFFFFF, 32'd1, 1'b0, "umax_1");
        check("umax_1:const", bus.result, {32'h0, 32'hFFFFFFFF});
        run_div(32'd123, 32'd0, 1'b0, "div0");
        check("div0:const", bus.result, 64'd0);
        run_div(32'd1000, 32'd9, 1'b0, "u1000_9");

        // Annul ten cycles into a divide.
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd5555;
        bus.opdata2    = 32'd3;
        repeat (10) begin
            @(posedge clk); #1;
        end
        bus.annul = 1'b1;
        bus.start = 1'b0;
        #1;
        check("annul:stall_follows_start", 64'(bus.stall_div), 64'd0);
        @(posedge clk); #1;
        bus.annul = 1'b0;
        check("annul:no_ready", 64'(bus.ready), 64'd0);
        check("annul:result_kept", bus.result, last_result);
        check("annul:stall_idle", 64'(bus.stall_div), 64'd0);
        run_div(32'd77, 32'd5, 1'b0, "after_annul");

        // Asynchronous reset in the middle of a divide.
        @(posedge clk); #1;
        bus.opdata1 = 32'd5000;
        bus.opdata2 = 32'd7;
        repeat (5) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        #1;
        check("rst_mid:result", bus.result, 64'd0);
        check("rst_mid:ready", 64'(bus.ready), 64'd0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("rst_mid:held_ready", 64'(bus.ready), 64'd0);
        @(negedge clk) resetn = 1'b1;
        run_div(32'd9, 32'd3, 1'b0, "after_rst");
        check("after_rst:const", bus.result, {32'd0, 32'd3});

        // Randomized operands, with occasional idle gaps between divides.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            logic        sgn;
            int          mode;
            a    = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFFFFFF;
                3:       b = 32'($urandom_range(1, 15));
                4:       b = 32'h80000000;
                default: b = $urandom;
            endcase
            if (mode == 5) a = 32'h80000000;
            sgn = 1'($urandom_range(0, 1));
            run_div(a, b, sgn, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                bus.start = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end

        @(posedge clk); #1;
        bus.start = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
